sonic_st_error_adapter_reg: RTL and testbench
=============================================

// Module: sonic_st_error_adapter_reg
// PURPOSE
//  Registered, parametrised Avalon-ST error adapter for the 10G MAC TX/RX streaming paths.
//  - Maps an IN_ERR_W error field onto an OUT_ERR_W field through a per-output-bit mask table.
//  - Optionally accumulates errors across a packet so they are all reported on the EOP beat.
//  - Flags SOP/EOP framing violations and counts errored packets.
//  - A skid buffer breaks the ready path, so it can sit between pause-ctrl and CRC/link stages.
// PARAMETERS
//  DATA_W        64      data bus width
//  EMPTY_W       3       empty field width; must equal log2(DATA_W/8)
//  IN_ERR_W      1       input error width
//  OUT_ERR_W     2       output error width
//  ERR_MAP       2'b01   flat masks, OUT_ERR_W*IN_ERR_W bits; out bit j uses mask slice [j*IN_ERR_W +: IN_ERR_W]
//  ACCUM_ERR     1       1: sticky OR of mapped errors reported on EOP beat; 0: per-beat only
//  FRAME_ERR_BIT 1       out_error bit set on framing violation; -1 disables framing checks
//  CNT_W         32      errored-packet counter width
// PORTS
//  clk                input   1          single clock domain
//  reset              input   1          asynchronous, active-high reset
//  in_ready           output  1          sink ready (ready latency 0)
//  in_valid           input   1          sink valid
//  in_data            input   DATA_W     sink data
//  in_error           input   IN_ERR_W   sink error
//  in_startofpacket   input   1          sink SOP
//  in_endofpacket     input   1          sink EOP
//  in_empty           input   EMPTY_W    sink empty
//  out_ready          input   1          source ready (ready latency 0)
//  out_valid          output  1          source valid
//  out_data           output  DATA_W     source data
//  out_error          output  OUT_ERR_W  source error
//  out_startofpacket  output  1          source SOP
//  out_endofpacket    output  1          source EOP
//  out_empty          output  EMPTY_W    source empty
//  cnt_clr            input   1          synchronous clear of err_pkt_cnt
//  err_pkt_cnt        output  CNT_W      saturating count of output EOP beats with out_error != 0
// BEHAVIOUR
//  Reset: all outputs 0, including in_ready; FSM = IDLE; accumulator 0.
//    in_ready rises on the first clk edge after reset deasserts.
//  Handshake: accept = in_valid & in_ready; emit = out_valid & out_ready.
//    Output is registered; latency is 1 cycle with no stall.
//    in_ready = ~skid_full (registered). Holds 2 beats; throughput 1 beat/clk under continuous out_ready.
//    When out_valid & ~out_ready, out_* are stable until emit.
//  Mapping: map_err[j] = |(in_error & ERR_MAP[j*IN_ERR_W +: IN_ERR_W]).
//  FSM advances on accept only:
//    IDLE:   SOP & ~EOP -> IN_PKT.  SOP & EOP -> IDLE.
//            ~SOP -> framing violation; beat is treated as SOP (-> IN_PKT unless EOP).
//    IN_PKT: EOP -> IDLE.
//            SOP -> framing violation; accumulator restarts with this beat; stays IN_PKT (-> IDLE if EOP).
//  Framing violation: out_error[FRAME_ERR_BIT] = 1 on that beat; the bit also enters the accumulator.
//  Accumulator: cleared on SOP-type beats, then accum |= map_err each accepted beat.
//    ACCUM_ERR=1: EOP beat carries accum | map_err | frame bit; non-EOP beats carry map_err | frame bit.
//    Accumulator clears after the EOP beat.
//  Counter:
//    Increments on emit & out_endofpacket & |out_error; saturates at all-ones.
//    cnt_clr wins over a simultaneous increment.
//  Data, empty, SOP and EOP pass unmodified; empty is not checked on non-EOP beats.
//  Reset mid-packet: the in-flight beats in the skid/output registers are dropped; the FSM returns to IDLE.
//    The next beat without SOP is flagged as a framing violation.
// STRUCTURE
//  Shared package sonic_st_pkg: ST_EMPTY_W(DATA_W) function, FRAME_ERR_DISABLE = -1, FSM state encodings.
//  One sub-module, sonic_st_skid_buffer: generic 2-entry ready/valid register stage of width
//    DATA_W+OUT_ERR_W+EMPTY_W+2.
//  The top level holds the error map, framing FSM, accumulator and counter.
// TESTING
//  1. 1-beat pkt (SOP&EOP), in_error=1, defaults, out_ready=1
//       -> out 1 clk later, out_error=2'b01, err_pkt_cnt=1.
//  2. 4-beat pkt, error only on beat 2, ACCUM_ERR=1
//       -> beats 1..4 out_error = 00, 01, 00, 01; count +1.
//  3. Beat without SOP in IDLE -> out_error[1]=1; next SOP-framed clean pkt -> out_error=00.
//  4. out_ready low for 3 clks mid-packet
//       -> in_ready drops after 2 beats held; no beat lost or duplicated; order preserved.
//  5. CNT_W=2, 5 errored pkts -> err_pkt_cnt = 3 (saturated).
//       cnt_clr coincident with an errored EOP -> 0.
//  6. Assert reset while 2 beats are buffered
//       -> out_valid=0, in_ready=0 during reset; FSM IDLE after; no stale beat emitted.

Source files
------------

// File: rtl/sonic_st_pkg.sv
// Shared definitions for the sonic streaming adapters: empty-width helper,
// framing-check disable value and framing FSM state encodings.
package sonic_st_pkg;

  // Value of FRAME_ERR_BIT that turns the SOP/EOP framing checks off.
  localparam int FRAME_ERR_DISABLE = -1;

  // Framing tracker: outside a packet, or between SOP and EOP.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } frame_state_e;

  // Width of the Avalon-ST empty field for a byte-granular data bus.
  function automatic int ST_EMPTY_W(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/sonic_st_skid_buffer.sv
// Two-entry ready/valid register stage. The output register is the primary
// entry; the skid register catches the beat accepted while the output stalls.
// in_ready is registered so the sink never sees a combinational path from
// out_ready.
module sonic_st_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  output logic         in_ready,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         ready_reg;
  logic         out_valid_reg;
  logic [W-1:0] out_data_reg;
  logic         skid_valid_reg;
  logic [W-1:0] skid_data_reg;
  logic         accept;
  logic         out_free;
  logic         ready_next;

  assign accept   = in_valid & ready_reg;
  // Output slot is available when empty or being emitted this cycle.
  assign out_free = ~out_valid_reg | out_ready;
  // Skid ends up occupied only when the output stalls and it holds or takes a beat.
  assign ready_next = ~(~out_free & (skid_valid_reg | accept));

  assign in_ready  = ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  // Move beats sink -> output register, or into the skid when the output stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_reg      <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
    end else begin
      ready_reg <= ready_next;
      if (out_free) begin
        if (skid_valid_reg) begin
          out_valid_reg  <= 1'b1;
          out_data_reg   <= skid_data_reg;
          skid_valid_reg <= 1'b0;
        end else begin
          out_valid_reg <= accept;
          if (accept) begin
            out_data_reg <= in_data;
          end
        end
      end else if (accept) begin
        skid_valid_reg <= 1'b1;
        skid_data_reg  <= in_data;
      end
    end
  end

endmodule

// File: rtl/sonic_st_error_adapter_reg.sv
// Registered Avalon-ST error adapter: maps the sink error field onto the
// source error field, optionally gathers a packet's errors onto its EOP beat,
// flags SOP/EOP framing violations and counts errored packets leaving the block.
module sonic_st_error_adapter_reg
  import sonic_st_pkg::*;
#(
  parameter int                            DATA_W        = 64,
  parameter int                            EMPTY_W       = 3,
  parameter int                            IN_ERR_W      = 1,
  parameter int                            OUT_ERR_W     = 2,
  parameter logic [OUT_ERR_W*IN_ERR_W-1:0] ERR_MAP       = 2'b01,
  parameter int                            ACCUM_ERR     = 1,
  parameter int                            FRAME_ERR_BIT = 1,
  parameter int                            CNT_W         = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 in_ready,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [IN_ERR_W-1:0]  in_error,
  input  logic                 in_startofpacket,
  input  logic                 in_endofpacket,
  input  logic [EMPTY_W-1:0]   in_empty,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic [OUT_ERR_W-1:0] out_error,
  output logic                 out_startofpacket,
  output logic                 out_endofpacket,
  output logic [EMPTY_W-1:0]   out_empty,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     err_pkt_cnt
);

  localparam int BUF_W = DATA_W + OUT_ERR_W + EMPTY_W + 2;

  frame_state_e           state_reg, state_next;
  logic [OUT_ERR_W-1:0]   accum_reg, accum_next;
  logic [CNT_W-1:0]       cnt_reg;

  logic                   accept;
  logic                   is_idle;
  logic                   sop_type;
  logic                   frame_viol;
  logic [OUT_ERR_W-1:0]   map_err;
  logic [OUT_ERR_W-1:0]   frame_vec;
  logic [OUT_ERR_W-1:0]   beat_err;
  logic [OUT_ERR_W-1:0]   beat_acc;
  logic [OUT_ERR_W-1:0]   err_in_buf;
  logic [BUF_W-1:0]       buf_in;
  logic [BUF_W-1:0]       buf_out;

  assign accept  = in_valid & in_ready;
  assign is_idle = (state_reg == ST_IDLE);
  // A non-SOP beat in IDLE is treated as a packet start; a SOP inside a packet restarts it.
  assign sop_type = in_startofpacket | is_idle;

  // Each output error bit is the OR of the input error bits selected by its mask slice.
  generate
    for (genvar gi = 0; gi < OUT_ERR_W; gi++) begin : g_map
      assign map_err[gi] = |(in_error & ERR_MAP[gi*IN_ERR_W +: IN_ERR_W]);
    end
  endgenerate

  // Framing violation: missing SOP outside a packet, or unexpected SOP inside one.
  generate
    if (FRAME_ERR_BIT != FRAME_ERR_DISABLE) begin : g_frame_on
      assign frame_viol = is_idle ? ~in_startofpacket : in_startofpacket;
      for (genvar gi = 0; gi < OUT_ERR_W; gi++) begin : g_fbit
        assign frame_vec[gi] = frame_viol & (gi == FRAME_ERR_BIT);
      end
    end else begin : g_frame_off
      assign frame_viol = 1'b0;
      assign frame_vec  = '0;
    end
  endgenerate

  assign beat_err = map_err | frame_vec;
  assign beat_acc = (sop_type ? '0 : accum_reg) | beat_err;

  // EOP beats report the whole packet's errors when accumulation is enabled.
  assign err_in_buf = ((ACCUM_ERR != 0) && in_endofpacket) ? beat_acc : beat_err;

  assign buf_in = {in_data, err_in_buf, in_empty, in_startofpacket, in_endofpacket};

  sonic_st_skid_buffer #(
    .W (BUF_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_ready  (in_ready),
    .in_valid  (in_valid),
    .in_data   (buf_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (buf_out)
  );

  assign {out_data, out_error, out_empty, out_startofpacket, out_endofpacket} = buf_out;

  // Framing state and error accumulator registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      accum_reg <= '0;
    end else begin
      state_reg <= state_next;
      accum_reg <= accum_next;
    end
  end

  // Next framing state and accumulator, advancing only on accepted beats.
  always_comb begin
    state_next = state_reg;
    accum_next = accum_reg;
    if (accept) begin
      if (in_endofpacket) begin
        state_next = ST_IDLE;
        accum_next = '0;
      end else begin
        state_next = ST_IN_PKT;
        accum_next = beat_acc;
      end
    end
  end

  // Saturating count of errored EOP beats leaving the block; clear has priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (cnt_clr) begin
      cnt_reg <= '0;
    end else if (out_valid && out_ready && out_endofpacket && (|out_error) && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign err_pkt_cnt = cnt_reg;

endmodule

// File: tb/tb_sonic_st_error_adapter_reg.sv
// Directed bench for sonic_st_error_adapter_reg: error mapping, accumulation,
// framing flags, back-pressure, counter saturation/clear and mid-packet reset.
module tb_sonic_st_error_adapter_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_ready, in_valid;
  logic [63:0] in_data;
  logic [0:0]  in_error;
  logic        in_sop, in_eop;
  logic [2:0]  in_empty;
  logic        out_ready, out_valid;
  logic [63:0] out_data;
  logic [1:0]  out_error;
  logic        out_sop, out_eop;
  logic [2:0]  out_empty;
  logic        cnt_clr;
  logic [31:0] err_pkt_cnt;

  // Second instance with a 2-bit counter, fed from the same sink and ready.
  logic        in_ready2, out_valid2, out_sop2, out_eop2;
  logic [63:0] out_data2;
  logic [1:0]  out_error2;
  logic [2:0]  out_empty2;
  logic [1:0]  err_pkt_cnt2;

  int n_checks = 0;
  int n_pass   = 0;
  logic [70:0] mon_q[$];

  always #5 clk = ~clk;

  sonic_st_error_adapter_reg dut (
    .clk(clk), .reset(reset),
    .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data), .in_error(in_error),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_empty(in_empty),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_error(out_error),
    .out_startofpacket(out_sop), .out_endofpacket(out_eop), .out_empty(out_empty),
    .cnt_clr(cnt_clr), .err_pkt_cnt(err_pkt_cnt)
  );

  sonic_st_error_adapter_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .in_ready(in_ready2), .in_valid(in_valid), .in_data(in_data), .in_error(in_error),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_empty(in_empty),
    .out_ready(out_ready), .out_valid(out_valid2), .out_data(out_data2), .out_error(out_error2),
    .out_startofpacket(out_sop2), .out_endofpacket(out_eop2), .out_empty(out_empty2),
    .cnt_clr(cnt_clr), .err_pkt_cnt(err_pkt_cnt2)
  );

  // Record every beat leaving the main instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (out_valid && out_ready)
      mon_q.push_back({out_data, out_empty, out_error, out_sop, out_eop});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send(input logic [63:0] d, input logic e, input logic s, input logic eo,
                      input logic [2:0] emp);
    bit ok;
    ok       = 1'b0;
    in_data  = d;
    in_error = e;
    in_sop   = s;
    in_eop   = eo;
    in_empty = emp;
    in_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_error = 1'b0;
  endtask

  // Compare the oldest emitted beat against hand-computed fields.
  task automatic expect_beat(input string tag, input logic [63:0] d, input logic [2:0] emp,
                             input logic [1:0] e, input logic s, input logic eo);
    logic [70:0] got;
    if (mon_q.size() == 0) begin
      check({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      got = mon_q.pop_front();
      $display("beat %s data=0x%0h empty=%0d err=%b sop=%b eop=%b", tag, got[70:7],
               got[6:4], got[3:2], got[1], got[0]);
      check({tag, "_data"}, got[70:7], d);
      check({tag, "_ctl"}, {57'd0, got[6:0]}, {57'd0, emp, e, s, eo});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_error = '0; in_sop = 1'b0;
    in_eop = 1'b0; in_empty = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    tick(3);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_cnt", 64'(err_pkt_cnt), 64'd0);
    reset = 1'b0;
    check("rst_rel_ready_low", 64'(in_ready), 64'd0);
    tick(1);
    check("rst_rel_ready_high", 64'(in_ready), 64'd1);

    // 1: single-beat errored packet, one-cycle latency
    send(64'h1111, 1'b1, 1'b1, 1'b1, 3'd2);
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_out_error", 64'(out_error), 64'd1);
    tick(1);
    check("t1_cnt", 64'(err_pkt_cnt), 64'd1);
    expect_beat("t1", 64'h1111, 3'd2, 2'b01, 1'b1, 1'b1);

    // 2: four-beat packet, error on beat 2 only
    send(64'h2001, 1'b0, 1'b1, 1'b0, 3'd0);
    send(64'h2002, 1'b1, 1'b0, 1'b0, 3'd0);
    send(64'h2003, 1'b0, 1'b0, 1'b0, 3'd0);
    send(64'h2004, 1'b0, 1'b0, 1'b1, 3'd5);
    tick(2);
    expect_beat("t2_b1", 64'h2001, 3'd0, 2'b00, 1'b1, 1'b0);
    expect_beat("t2_b2", 64'h2002, 3'd0, 2'b01, 1'b0, 1'b0);
    expect_beat("t2_b3", 64'h2003, 3'd0, 2'b00, 1'b0, 1'b0);
    expect_beat("t2_b4", 64'h2004, 3'd5, 2'b01, 1'b0, 1'b1);
    check("t2_cnt", 64'(err_pkt_cnt), 64'd2);

    // 3: missing SOP in IDLE, then a clean framed packet
    send(64'h3001, 1'b0, 1'b0, 1'b1, 3'd1);
    send(64'h3002, 1'b0, 1'b1, 1'b0, 3'd0);
    send(64'h3003, 1'b0, 1'b0, 1'b1, 3'd3);
    tick(2);
    expect_beat("t3_viol", 64'h3001, 3'd1, 2'b10, 1'b0, 1'b1);
    expect_beat("t3_c1", 64'h3002, 3'd0, 2'b00, 1'b1, 1'b0);
    expect_beat("t3_c2", 64'h3003, 3'd3, 2'b00, 1'b0, 1'b1);
    check("t3_cnt", 64'(err_pkt_cnt), 64'd3);

    // 4: stall the source mid-packet for 3 clocks
    out_ready = 1'b0;
    send(64'h4001, 1'b0, 1'b1, 1'b0, 3'd0);
    send(64'h4002, 1'b1, 1'b0, 1'b0, 3'd0);
    check("t4_ready_drop", 64'(in_ready), 64'd0);
    tick(3);
    check("t4_ready_held", 64'(in_ready), 64'd0);
    check("t4_out_stable", out_data, 64'h4001);
    out_ready = 1'b1;
    send(64'h4003, 1'b0, 1'b0, 1'b0, 3'd0);
    send(64'h4004, 1'b0, 1'b0, 1'b1, 3'd7);
    tick(3);
    expect_beat("t4_b1", 64'h4001, 3'd0, 2'b00, 1'b1, 1'b0);
    expect_beat("t4_b2", 64'h4002, 3'd0, 2'b01, 1'b0, 1'b0);
    expect_beat("t4_b3", 64'h4003, 3'd0, 2'b00, 1'b0, 1'b0);
    expect_beat("t4_b4", 64'h4004, 3'd7, 2'b01, 1'b0, 1'b1);
    check("t4_no_extra", 64'(mon_q.size()), 64'd0);
    check("t4_cnt", 64'(err_pkt_cnt), 64'd4);
    check("t4_cnt2_sat", 64'(err_pkt_cnt2), 64'd3);

    // 5: clear, saturate the 2-bit counter, then clear against an errored EOP
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    check("t5_clr", 64'(err_pkt_cnt), 64'd0);
    check("t5_clr2", 64'(err_pkt_cnt2), 64'd0);
    for (int i = 0; i < 5; i++) send(64'h5000 + 64'(i), 1'b1, 1'b1, 1'b1, 3'd0);
    tick(2);
    check("t5_cnt", 64'(err_pkt_cnt), 64'd5);
    check("t5_cnt2_sat", 64'(err_pkt_cnt2), 64'd3);
    send(64'h5005, 1'b1, 1'b1, 1'b1, 3'd0);
    check("t5_eop_pending", 64'(out_valid & out_eop), 64'd1);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    check("t5_clr_wins", 64'(err_pkt_cnt), 64'd0);
    check("t5_clr_wins2", 64'(err_pkt_cnt2), 64'd0);
    mon_q.delete();

    // 6: reset with two beats buffered mid-packet
    out_ready = 1'b0;
    send(64'h6001, 1'b0, 1'b1, 1'b0, 3'd0);
    send(64'h6002, 1'b0, 1'b0, 1'b0, 3'd0);
    reset = 1'b1;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_ready", 64'(in_ready), 64'd0);
    tick(2);
    check("t6_rst_ready_hold", 64'(in_ready), 64'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    tick(3);
    check("t6_no_stale", 64'(mon_q.size()), 64'd0);
    check("t6_cnt_rst", 64'(err_pkt_cnt), 64'd0);
    send(64'h6003, 1'b0, 1'b0, 1'b1, 3'd4);
    tick(2);
    expect_beat("t6_viol", 64'h6003, 3'd4, 2'b10, 1'b0, 1'b1);
    check("t6_cnt", 64'(err_pkt_cnt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
